// File: rtl/mem_access_unit_if.sv
// Data-cache request/hit bus between the MEM-stage access unit (master)
// and the data cache (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dhit, dload
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dhit, dload
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: cache handshake, pipeline stall, LL/SC link.
// Optional ACCESS watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   dread_in,
  input  logic                   dwrite_in,
  input  logic                   datomic_in,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic [DATA_W-1:0]      store_in,
  input  logic                   snoop_inv,
  input  logic [ADDR_W-1:0]      snoop_addr,
  mem_access_unit_if.master      cbus,
  output logic [DATA_W-1:0]      load_out,
  output logic                   mem_stall,
  output logic                   mem_done,
  output logic                   link_valid,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_load_out;
  logic              r_link_valid;
  logic [ADDR_W-3:0] r_link_word;
  logic              r_timeout_err;

  logic w_op, w_is_load, w_is_store, w_is_ll, w_is_sc;
  logic w_link_match, w_snoop_link, w_snoop_addr, w_sc_fail;

  // A simultaneous load and store is resolved as a load.
  assign w_op         = dread_in | dwrite_in;
  assign w_is_load    = dread_in;
  assign w_is_store   = dwrite_in & ~dread_in;
  assign w_is_ll      = dread_in & datomic_in;
  assign w_is_sc      = w_is_store & datomic_in;
  assign w_link_match = (r_link_word == addr_in[ADDR_W-1:2]);
  assign w_snoop_link = snoop_inv & (snoop_addr[ADDR_W-1:2] == r_link_word);
  assign w_snoop_addr = snoop_inv & (snoop_addr[ADDR_W-1:2] == addr_in[ADDR_W-1:2]);
  assign w_sc_fail    = w_is_sc & (~r_link_valid | ~w_link_match | w_snoop_link);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
  logic [CNT_W-1:0] r_cnt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 32'd0);
`endif

  logic w_unused_bits;
  assign w_unused_bits = ^{snoop_addr[1:0], addr_in[1:0]};

  // FSM, load result register and LL/SC link register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_load_out    <= '0;
      r_link_valid  <= 1'b0;
      r_link_word   <= '0;
      r_timeout_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt         <= '0;
`endif
    end else begin
      // Snoops kill a matching link in every state; later writes may override.
      if (w_snoop_link) begin
        r_link_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            if (w_sc_fail) begin
              r_load_out <= '0;
              r_state    <= S_DONE;
            end else begin
`ifdef MEM_TIMEOUT_EN
              r_cnt      <= '0;
`endif
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (cbus.dhit) begin
            r_state <= S_DONE;
            if (w_is_load) begin
              r_load_out <= cbus.dload;
            end
            if (w_is_ll) begin
              r_link_word  <= addr_in[ADDR_W-1:2];
              r_link_valid <= ~w_snoop_addr;
            end
            if (w_is_sc) begin
              r_load_out   <= {{(DATA_W-1){1'b0}}, 1'b1};
              r_link_valid <= 1'b0;
            end
            if (w_is_store & ~datomic_in & w_link_match) begin
              r_link_valid <= 1'b0;
            end
          end else begin
`ifdef MEM_TIMEOUT_EN
            if (r_cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
              r_timeout_err <= 1'b1;
              r_load_out    <= '0;
              r_state       <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request is only presented in ACCESS; inputs are held by the frozen EX/MEM latch.
  assign cbus.dREN   = (r_state == S_ACCESS) & dread_in;
  assign cbus.dWEN   = (r_state == S_ACCESS) & w_is_store;
  assign cbus.daddr  = (r_state == S_ACCESS) ? {addr_in[ADDR_W-1:2], 2'b00} : '0;
  assign cbus.dstore = (r_state == S_ACCESS) ? store_in : '0;
  assign mem_stall   = (r_state == S_ACCESS) | ((r_state == S_IDLE) & w_op);
  assign mem_done    = (r_state == S_DONE);
  assign load_out    = r_load_out;
  assign link_valid  = r_link_valid;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory controller. Sits directly downstream of the EX/MEM pipeline latch and upstream of the MEM/WB latch.
- Turns the latched dread/dwrite/datomic controls, ALU address and store data into a held request/hit handshake with the data cache, and returns load data to MEM/WB.
- Stalls the pipeline while an access is outstanding.
- Owns the LL/SC link register, including invalidation by coherence snoops.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 255, ACCESS-state cycle limit used only when MEM_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, reset is synchronous and active-high
- dread_in  in  1  load request from EX/MEM latch
- dwrite_in  in  1  store request from EX/MEM latch
- datomic_in  in  1  with dread = LL, with dwrite = SC
- addr_in  in  ADDR_W  effective address (ALU result)
- store_in  in  DATA_W  store data
- dhit  in  1  cache completes current request this cycle
- dload  in  DATA_W  cache read data, valid with dhit
- snoop_inv  in  1  coherence invalidate this cycle
- snoop_addr  in  ADDR_W  invalidated address
- dREN  out  1  cache read enable
- dWEN  out  1  cache write enable
- daddr  out  ADDR_W  word-aligned cache address
- dstore  out  DATA_W  cache write data
- load_out  out  DATA_W  result to MEM/WB: load data, or SC status 0/1
- mem_stall  out  1  to hazard unit; freezes IF..EX/MEM while high
- mem_done  out  1  one-cycle pulse; load_out valid
- link_valid  out  1  LL link register valid (debug)
- timeout_err  out  1  sticky; only driven when MEM_TIMEOUT_EN is defined, else tied 0

Behaviour:
- States: IDLE, ACCESS, DONE. Reset puts the FSM in IDLE.
- Reset values: load_out=0, link_valid=0, link_addr=0, timeout_err=0, counter=0. Combinational outputs are 0 in IDLE.
- op = dread_in | dwrite_in.
- IDLE:
  - op=0: stay in IDLE, mem_stall=0.
  - op=1: mem_stall=1 combinationally.
  - SC fail (datomic&dwrite and (!link_valid or link_addr[31:2]!=addr_in[31:2] or a same-cycle matching snoop_inv)): go to DONE with load_out<=0. No cache write.
  - Otherwise go to ACCESS.
- ACCESS:
  - dREN=dread_in, dWEN=dwrite_in, daddr={addr_in[ADDR_W-1:2],2'b00}, dstore=store_in, all held stable. mem_stall=1.
  - Without dhit: stay in ACCESS.
  - On dhit, go to DONE:
    - Load: load_out<=dload.
    - SC: load_out<=1, link_valid<=0.
    - LL: link_addr<=addr_in, link_valid<=1.
    - Plain store to link_addr word: link_valid<=0.
- DONE:
  - mem_stall=0, mem_done=1, no request.
  - Next state is IDLE unconditionally. EX/MEM advances at this edge, so the same op is never reissued.
  - Plain store: load_out unchanged.
- Minimum latency: 2 cycles from op entering IDLE to mem_done (dhit in the first ACCESS cycle). SC fail takes 1 cycle.
- Snoop handling: snoop_inv with word match clears link_valid in any state. If it coincides with an LL dhit, the invalidate wins and link_valid stays 0.
- dread_in & dwrite_in both 1 is illegal. The load takes priority; dWEN is held 0.
- RST asserted mid-ACCESS: FSM goes to IDLE next edge, request drops, link cleared. The cache tolerates the abandoned request.
- mem_done and dhit never cause a request to be issued in DONE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without dhit.
  - Reaching TIMEOUT_CYCLES sets timeout_err (sticky until RST) and forces DONE with load_out<=0.
- Undefined: no counter; ACCESS waits indefinitely; timeout_err=0.

Test Plan:
- Load: dread_in=1, addr=0x104, dhit in 3rd ACCESS cycle with dload=0xDEADBEEF -> dREN=1, daddr=0x104 held for 3 cycles, mem_stall high 4 cycles, then mem_done pulse with load_out=0xDEADBEEF.
- Store: dwrite_in=1, addr=0x203, store=0x12345678, dhit immediate -> dWEN=1, daddr=0x200, dstore=0x12345678, mem_done 2 cycles after op; load_out unchanged.
- LL then SC, same word 0x40, no snoop -> link_valid=1 after LL; SC issues dWEN, load_out=1, link_valid=0.
- LL 0x40, snoop_inv addr 0x40, then SC 0x40 -> no dWEN ever asserted; load_out=0 one cycle after op; mem_done pulses.
- RST pulsed during ACCESS with dhit never asserted -> next cycle dREN=dWEN=0, mem_stall=0, link_valid=0, FSM in IDLE.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no dhit -> timeout_err=1 after 4 ACCESS cycles, mem_done with load_out=0, timeout_err stays 1 until RST.
